// File: rtl/core_mem_responder.sv
// Word-addressed 16-bit RAM responder with a fixed-latency response pipeline and a sticky out-of-range write flag.
// Optional memory-mapped output register enabled by defining MMIO_PORT_EN.
module core_mem_responder #(
  parameter int          ADDR_BITS    = 11,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] OOR_VALUE    = 16'hDEAD,
  parameter logic [23:0] MMIO_ADDR    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] core_to_mem_addr,
  input  logic [15:0] core_to_mem_data,
  input  logic        core_to_mem_write_enable,
  output logic [15:0] mem_to_core_data,
  output logic        mem_to_core_valid,
  output logic        mem_err
`ifdef MMIO_PORT_EN
  ,
  output logic [15:0] io_out
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("core_mem_responder: READ_LATENCY must be 1..4");
  end

  logic [15:0]             mem_r [DEPTH];
  logic [15:0]             data_pipe_r [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_pipe_r;
  logic                    mem_err_r;
  logic [ADDR_BITS-1:0]    index_s;
  logic                    in_range_s;
  logic                    mmio_hit_s;
  logic                    mem_write_s;
  logic                    oor_write_s;
  logic [15:0]             io_value_s;
  logic [15:0]             resp_data_s;

`ifdef MMIO_PORT_EN
  logic [15:0] io_out_r;

  // I/O register: written only by an access that hits MMIO_ADDR
  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_r <= 16'h0000;
    end else if (core_to_mem_write_enable && mmio_hit_s) begin
      io_out_r <= core_to_mem_data;
    end
  end

  assign io_out     = io_out_r;
  assign io_value_s = io_out_r;
`else
  logic unused_mmio_s;
  assign unused_mmio_s = &{1'b0, MMIO_ADDR};
  assign io_value_s    = 16'h0000;
`endif

  // Address decode and the response value for this cycle's access
  always_comb begin
    index_s    = core_to_mem_addr[ADDR_BITS-1:0];
    in_range_s = (core_to_mem_addr[23:ADDR_BITS] == {(24-ADDR_BITS){1'b0}});
`ifdef MMIO_PORT_EN
    mmio_hit_s = (core_to_mem_addr == MMIO_ADDR);
`else
    mmio_hit_s = 1'b0;
`endif
    mem_write_s = core_to_mem_write_enable && in_range_s && !mmio_hit_s;
    oor_write_s = core_to_mem_write_enable && !in_range_s && !mmio_hit_s;
    if (core_to_mem_write_enable) begin
      resp_data_s = core_to_mem_data;
    end else if (mmio_hit_s) begin
      resp_data_s = io_value_s;
    end else if (in_range_s) begin
      resp_data_s = mem_r[index_s];
    end else begin
      resp_data_s = OOR_VALUE;
    end
  end

  // Array write port; contents deliberately survive reset, but a reset cycle performs no write
  always_ff @(posedge clk) begin
    if (!reset && mem_write_s) begin
      mem_r[index_s] <= core_to_mem_data;
    end
  end

  // Response pipeline: stage0 captures this access, later stages shift one per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_pipe_r[i] <= 16'h0000;
      end
      valid_pipe_r <= {READ_LATENCY{1'b0}};
    end else begin
      data_pipe_r[0]  <= resp_data_s;
      valid_pipe_r[0] <= 1'b1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        data_pipe_r[i]  <= data_pipe_r[i-1];
        valid_pipe_r[i] <= valid_pipe_r[i-1];
      end
    end
  end

  // Sticky out-of-range write flag
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err_r <= 1'b0;
    end else if (oor_write_s) begin
      mem_err_r <= 1'b1;
    end
  end

  assign mem_to_core_data  = data_pipe_r[READ_LATENCY-1];
  assign mem_to_core_valid = valid_pipe_r[READ_LATENCY-1];
  assign mem_err           = mem_err_r;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: a latency-1 and a latency-3 instance share one stimulus bus.
// Build with MMIO_PORT_EN defined to exercise the I/O register.
module tb_core_mem_responder;

`ifdef MMIO_PORT_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] d1_data, d3_data;
  logic        d1_valid, d3_valid, d1_err, d3_err;
`ifdef MMIO_PORT_EN
  logic [15:0] d1_io, d3_io;
`endif

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_mem_responder #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .core_to_mem_addr(addr), .core_to_mem_data(wdata),
    .core_to_mem_write_enable(we), .mem_to_core_data(d1_data),
    .mem_to_core_valid(d1_valid), .mem_err(d1_err)
`ifdef MMIO_PORT_EN
    , .io_out(d1_io)
`endif
  );

  core_mem_responder #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .core_to_mem_addr(addr), .core_to_mem_data(wdata),
    .core_to_mem_write_enable(we), .mem_to_core_data(d3_data),
    .mem_to_core_valid(d3_valid), .mem_err(d3_err)
`ifdef MMIO_PORT_EN
    , .io_out(d3_io)
`endif
  );

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic        we;
    logic [15:0] exp_data;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one access, let the edge take it, and sample 1 time unit later
  task automatic access(input logic [23:0] a, input logic [15:0] d, input logic w);
    addr  = a;
    wdata = d;
    we    = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{24'h000005, 16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[1]  = '{24'h000005, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0};
    vecs[2]  = '{24'h000010, 16'hAAAA, 1'b1, 16'hAAAA, 1'b1, 1'b0};
    vecs[3]  = '{24'h000010, 16'h0000, 1'b0, 16'hAAAA, 1'b1, 1'b0};
    vecs[4]  = '{24'h000000, 16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 1'b0};
    vecs[5]  = '{24'h000800, 16'h0000, 1'b0, 16'hDEAD, 1'b1, 1'b0};
    vecs[6]  = '{24'h0007FF, 16'h7777, 1'b1, 16'h7777, 1'b1, 1'b0};
    vecs[7]  = '{24'h0007FF, 16'h0000, 1'b0, 16'h7777, 1'b1, 1'b0};
    vecs[8]  = '{24'hFFFFFF, 16'h00FF, 1'b1, 16'h00FF, 1'b1, !MMIO_ON};
    vecs[9]  = '{24'hFFFFFF, 16'h0000, 1'b0, MMIO_ON ? 16'h00FF : 16'hDEAD, 1'b1, !MMIO_ON};
    vecs[10] = '{24'h000800, 16'h5555, 1'b1, 16'h5555, 1'b1, 1'b1};
    vecs[11] = '{24'h000000, 16'h0000, 1'b0, 16'h0F0F, 1'b1, 1'b1};
    vecs[12] = '{24'h000005, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b1};
    vecs[13] = '{24'h000020, 16'h2020, 1'b1, 16'h2020, 1'b1, 1'b1};
    vecs[14] = '{24'h800005, 16'h0000, 1'b0, 16'hDEAD, 1'b1, 1'b1};
    vecs[15] = '{24'h0007FF, 16'h0000, 1'b0, 16'h7777, 1'b1, 1'b1};

    // Two reset cycles with a write pending that must be ignored
    reset = 1'b1;
    access(24'h000005, 16'hBEEF, 1'b1);
    access(24'h000005, 16'hBEEF, 1'b1);
    chk("reset_valid1", {15'h0000, d1_valid}, 16'h0000);
    chk("reset_data1", d1_data, 16'h0000);
    chk("reset_err1", {15'h0000, d1_err}, 16'h0000);
    chk("reset_valid3", {15'h0000, d3_valid}, 16'h0000);
`ifdef MMIO_PORT_EN
    chk("reset_io", d1_io, 16'h0000);
`endif
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      access(vecs[i].addr, vecs[i].data, vecs[i].we);
      chk($sformatf("vec%0d_data", i), d1_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_valid", i), {15'h0000, d1_valid}, {15'h0000, vecs[i].exp_valid});
      chk($sformatf("vec%0d_err", i), {15'h0000, d1_err}, {15'h0000, vecs[i].exp_err});
    end
`ifdef MMIO_PORT_EN
    chk("io_out_value", d1_io, 16'h00FF);
`endif

    // Latency-3 streaming: preload 0..9, reset, then ten back-to-back reads
    for (int i = 0; i < 10; i++) access(24'(i), 16'hC000 + 16'(i), 1'b1);
    reset = 1'b1;
    access(24'h000000, 16'h0000, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      access((k < 10) ? 24'(k) : 24'h000000, 16'h0000, 1'b0);
      chk($sformatf("lat3_valid%0d", k), {15'h0000, d3_valid}, (k >= 2) ? 16'h0001 : 16'h0000);
      chk($sformatf("lat3_data%0d", k), d3_data, (k >= 2) ? 16'hC000 + 16'(k - 2) : 16'h0000);
    end

    // Reset with a write to 0x020 pending while responses are in flight
    access(24'h000005, 16'h0000, 1'b0);
    access(24'h0007FF, 16'h0000, 1'b0);
    reset = 1'b1;
    access(24'h000020, 16'hBAD0, 1'b1);
    reset = 1'b0;
    chk("midrst_valid1", {15'h0000, d1_valid}, 16'h0000);
    chk("midrst_data1", d1_data, 16'h0000);
    chk("midrst_valid3", {15'h0000, d3_valid}, 16'h0000);
    chk("midrst_data3", d3_data, 16'h0000);
    chk("midrst_err", {15'h0000, d1_err}, 16'h0000);
`ifdef MMIO_PORT_EN
    chk("midrst_io", d1_io, 16'h0000);
`endif
    access(24'h000020, 16'h0000, 1'b0);
    chk("post_020", d1_data, 16'h2020);
    chk("post_v3_a", {15'h0000, d3_valid}, 16'h0000);
    access(24'h0007FF, 16'h0000, 1'b0);
    chk("post_7ff", d1_data, 16'h7777);
    chk("post_v3_b", {15'h0000, d3_valid}, 16'h0000);
    access(24'h000003, 16'h0000, 1'b0);
    chk("post_003", d1_data, 16'hC003);
    chk("post_v3_c", {15'h0000, d3_valid}, 16'h0001);
    chk("post_d3_c", d3_data, 16'h2020);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
